// File: rtl/pix_pkg.sv
// Shared definitions for the pixel-window assembler: default geometry, FSM encoding, lane-index width.
package pix_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int NPIX_DEF   = 3;
  localparam int STRIDE_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // Lane counter width; never below one bit so a 2-pixel window still gets a counter
  function automatic int clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pix_window_buffer_if.sv
// Pixel-in / window-out handshake bundle; slave is the buffer's view, master is the source/consumer side.
interface pix_window_buffer_if #(
  parameter int PIX_W = pix_pkg::PIX_W_DEF,
  parameter int NPIX  = pix_pkg::NPIX_DEF
);

  logic [PIX_W-1:0]      in_pix;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [NPIX*PIX_W-1:0] out_win;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  in_pix, in_valid, in_last, out_ready,
    output in_ready, out_win, out_valid, out_last
  );

  modport master (
    output in_pix, in_valid, in_last, out_ready,
    input  in_ready, out_win, out_valid, out_last
  );

endinterface

// File: rtl/pix_window_shift.sv
// Combinational lane shifter: drops the STRIDE oldest lanes, moves lane j+STRIDE to lane j, zero-fills the top.
module pix_window_shift
  import pix_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int NPIX   = NPIX_DEF,
  parameter int STRIDE = STRIDE_DEF
) (
  input  logic [NPIX*PIX_W-1:0] win,
  output logic [NPIX*PIX_W-1:0] shifted
);

  // Lane 0 sits at the LSBs, so a logical right shift discards the oldest lanes
  assign shifted = win >> (STRIDE * PIX_W);

endmodule

// File: rtl/pix_window_buffer.sv
// Packs PIX_W pixels into NPIX-lane windows with a sliding STRIDE; 1-cycle accept-to-out_valid, one-window skid (FULL) on stall.
// PIX_WINDOW_ZERO_PAD_EN: zero-pad and emit partial rows; when undefined partial rows are dropped and flagged on win_drop.
module pix_window_buffer
  import pix_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int NPIX   = NPIX_DEF,
  parameter int STRIDE = STRIDE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  pix_window_buffer_if.slave       bus
`ifndef PIX_WINDOW_ZERO_PAD_EN
  ,
  output logic                     win_drop
`endif
);

  localparam int            LW        = clog2(NPIX);
  localparam logic [LW-1:0] LAST_LANE = LW'(NPIX - 1);
  localparam logic [LW-1:0] REFILL    = LW'(NPIX - STRIDE);

  typedef logic [NPIX-1:0][PIX_W-1:0] win_t;

  state_t        state_q, state_d;
  win_t          asm_q, asm_wr, win_src, win_shift;
  logic [LW-1:0] cnt_q;
  logic          pend_last_q;
  logic          acc, at_top, fire, slot_free, load, stall, last_src;

  assign bus.in_ready = (state_q == FILL);
  assign acc          = bus.in_valid && bus.in_ready;
  assign at_top       = (cnt_q == LAST_LANE);
  assign slot_free    = !bus.out_valid || bus.out_ready;

`ifdef PIX_WINDOW_ZERO_PAD_EN
  assign fire = acc && (at_top || bus.in_last);
`else
  assign fire = acc && at_top;
`endif

  // Assembly register with the incoming pixel dropped into lane cnt
  always_comb begin
    asm_wr        = asm_q;
    asm_wr[cnt_q] = bus.in_pix;
`ifdef PIX_WINDOW_ZERO_PAD_EN
    for (int k = 0; k < NPIX; k++) begin
      if (k > int'(cnt_q)) asm_wr[k] = '0;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    stall    = 1'b0;
    win_src  = asm_wr;
    last_src = bus.in_last;
    case (state_q)
      FILL: begin
        if (fire) begin
          if (slot_free) begin
            load = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        win_src  = asm_q;
        last_src = pend_last_q;
        if (bus.out_ready) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  pix_window_shift #(
    .PIX_W  (PIX_W),
    .NPIX   (NPIX),
    .STRIDE (STRIDE)
  ) u_shift (
    .win     (win_src),
    .shifted (win_shift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_win   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      asm_q         <= '0;
      cnt_q         <= '0;
      pend_last_q   <= 1'b0;
`ifndef PIX_WINDOW_ZERO_PAD_EN
      win_drop      <= 1'b0;
`endif
    end else begin
`ifndef PIX_WINDOW_ZERO_PAD_EN
      win_drop <= 1'b0;
`endif
      if (load) begin
        bus.out_win   <= win_src;
        bus.out_valid <= 1'b1;
        bus.out_last  <= last_src;
        asm_q         <= win_shift;
        cnt_q         <= last_src ? '0 : REFILL;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end
        if (stall) begin
          asm_q       <= asm_wr;
          pend_last_q <= bus.in_last;
        end else if (acc) begin
`ifdef PIX_WINDOW_ZERO_PAD_EN
          asm_q <= asm_wr;
          cnt_q <= cnt_q + 1'b1;
`else
          if (bus.in_last) begin
            asm_q    <= '0;
            cnt_q    <= '0;
            win_drop <= 1'b1;
          end else begin
            asm_q <= asm_wr;
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pix_window_buffer.sv
// Scoreboard bench for pix_window_buffer (NPIX=3, STRIDE=1); builds with or without PIX_WINDOW_ZERO_PAD_EN.
// A pixel-list reference model predicts windows; a negedge monitor pops and compares on each output handshake.
module tb_pix_window_buffer;

  localparam int PIX_W  = 8;
  localparam int NPIX   = 3;
  localparam int STRIDE = 1;
  localparam int WW     = NPIX * PIX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pix_window_buffer_if #(.PIX_W(PIX_W), .NPIX(NPIX)) bus ();
`ifndef PIX_WINDOW_ZERO_PAD_EN
  logic win_drop;
`endif

  pix_window_buffer #(
    .PIX_W  (PIX_W),
    .NPIX   (NPIX),
    .STRIDE (STRIDE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifndef PIX_WINDOW_ZERO_PAD_EN
    ,
    .win_drop (win_drop)
`endif
  );

  typedef struct packed {
    logic [WW-1:0] win;
    logic          last;
  } exp_t;

  exp_t             exp_q[$];
  logic [PIX_W-1:0] mbuf[$];
  exp_t             mon_e;
  int n_checks   = 0;
  int n_pass     = 0;
  int drops_exp  = 0;
  int drops_seen = 0;
  bit ready_mode = 1'b0;
  bit chk_rdy    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [WW-1:0] pack_win();
    logic [WW-1:0] w = '0;
    foreach (mbuf[k]) w[k*PIX_W +: PIX_W] = mbuf[k];
    return w;
  endfunction

  // Reference: collect pixels of the current window; emit when NPIX gathered or the row ends
  task automatic model_accept(input logic [PIX_W-1:0] p, input logic l);
    mbuf.push_back(p);
    if (mbuf.size() == NPIX) begin
      exp_q.push_back('{pack_win(), l});
      if (l) mbuf.delete();
      else for (int i = 0; i < STRIDE; i++) void'(mbuf.pop_front());
    end else if (l) begin
`ifdef PIX_WINDOW_ZERO_PAD_EN
      exp_q.push_back('{pack_win(), 1'b1});
`else
      drops_exp++;
`endif
      mbuf.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_window: got 0x%0h, expected no window", bus.out_win);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_win", bus.out_win, mon_e.win);
        check("sb_last", bus.out_last, mon_e.last);
      end
    end
  end

`ifndef PIX_WINDOW_ZERO_PAD_EN
  always @(negedge clk) if (!rst && win_drop) drops_seen++;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [PIX_W-1:0] p, input logic l);
    logic rdy;
    bus.in_pix   = p;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      if (chk_rdy) check("b2b_in_ready", rdy, 1);
      tick();
      if (rdy) begin
        model_accept(p, l);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        return;
      end
    end
    n_checks++;
    $display("FAIL send_timeout: pixel 0x%0h not accepted within 100 cycles", p);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    mbuf.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_pix    = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    do_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_win", bus.out_win, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 1);
`ifndef PIX_WINDOW_ZERO_PAD_EN
    check("rst_win_drop", win_drop, 0);
`endif

    // First window latency and sliding by one lane
    bus.out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_win", bus.out_win, 24'h332211);
    send(8'h44, 1'b0);
    check("slide_out_win", bus.out_win, 24'h443322);
    send(8'h55, 1'b1);
    check("slide_out_last", bus.out_last, 1);
    repeat (2) tick();

    // Output stall pushes the buffer into FULL, then drains without a bubble
    do_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    for (int i = 0; i < STRIDE; i++) send(8'(4 + i), 1'b0);
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_win", bus.out_win, 24'h030201);
    tick();
    check("stall_hold_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    tick();
    check("drain_in_ready", bus.in_ready, 1);
    check("drain_out_valid", bus.out_valid, 1);
    check("drain_out_win", bus.out_win, 24'h040302);
    tick();

    // Partial row
    do_reset();
    bus.out_ready = 1'b1;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
`ifdef PIX_WINDOW_ZERO_PAD_EN
    check("part_out_valid", bus.out_valid, 1);
    check("part_out_last", bus.out_last, 1);
    check("part_out_win", bus.out_win, 24'h00BBAA);
`else
    check("part_win_drop", win_drop, 1);
    check("part_out_valid", bus.out_valid, 0);
`endif
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    check("part_next_win", bus.out_win, 24'h030201);
    repeat (2) tick();

    // Asynchronous reset while FULL
    do_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    for (int i = 0; i < STRIDE; i++) send(8'(4 + i), 1'b0);
    check("full_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_win", bus.out_win, 0);
    check("arst_out_last", bus.out_last, 0);
    exp_q.delete();
    mbuf.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    check("arst_fresh_win", bus.out_win, 24'h0C0B0A);

    // Back-to-back with a always-ready consumer: input never stalls
    chk_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send(8'($urandom), 1'b0);
    chk_rdy = 1'b0;
    send(8'($urandom), 1'b1);

    // Randomised traffic, row ends and consumer stalls
    ready_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(8'($urandom), ($urandom_range(0, 7) == 0));
    end
    ready_mode    = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    repeat (2) tick();

    check("sb_empty", exp_q.size(), 0);
`ifndef PIX_WINDOW_ZERO_PAD_EN
    check("drop_count", drops_seen, drops_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pix_window_buffer.md
Name: pix_window_buffer

Overview:
- Parametrised pixel-window assembler feeding the conv datapath; successor to the fixed 3-pixel byte buffer.
- Packs a stream of PIX_W-bit pixels into NPIX-pixel windows.
- Supports a sliding stride, valid/ready handshakes on both sides and row-end flushing.
- Sits between the pixel source and the convolution MAC array.

Parameters:
PIX_W, 8, pixel width in bits
NPIX, 3, pixels per window (>=2)
STRIDE, 3, pixels advanced per emitted window (1..NPIX); STRIDE=NPIX gives non-overlapping windows

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_pix  in  PIX_W  input pixel
in_valid  in  1  in_pix valid
in_ready  out  1  block can accept a pixel this cycle
in_last  in  1  qualifies in_pix as the last pixel of a row
out_win  out  NPIX*PIX_W  window; pixel k at bits [k*PIX_W +: PIX_W], oldest at lane 0
out_valid  out  1  out_win valid
out_ready  in  1  consumer accepts out_win
out_last  out  1  window closed by in_last

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - out_win=0, out_valid=0, out_last=0.
  - Assembly register asm=0, lane counter cnt=0, state FILL, pending_last=0.
  - in_ready=1 after reset.
- Accept: in_valid && in_ready at a clk edge. The pixel is written to lane cnt of asm.
- in_ready = (state==FILL). Combinational from state only; no dependence on in_valid.
- Window completes when the accepted pixel lands in lane NPIX-1. Let W be the completed window.
- On completion, if the output slot is free (!out_valid || out_ready):
  - out_win<=W, out_valid<=1, out_last<=in_last.
  - asm<=W shifted down by STRIDE lanes, zero-filled at the top.
  - cnt<=NPIX-STRIDE, or cnt<=0 if in_last.
  - Latency is 1 cycle from accept to out_valid.
- On completion, if the output slot is stalled:
  - asm<=W, pending_last<=in_last, state<=FULL.
- State FULL:
  - No input is accepted.
  - When out_ready is high: out_win<=asm, out_valid<=1, out_last<=pending_last.
  - asm is shifted and cnt updated as above, using pending_last in place of in_last.
  - state<=FILL.
- Output consumed (out_valid && out_ready) with no new load: out_valid<=0 and out_last<=0. out_win holds its value.
- Throughput: one window per STRIDE accepted pixels when the consumer is always ready.
- Partial row (in_last accepted with cnt<NPIX-1): behaviour depends on the macro (see Optional Feature). In both cases cnt<=0 afterwards.
- Lane 0 is always the oldest pixel. Retained lanes after a shift: asm lane j <= W lane j+STRIDE.
- Reset mid-operation: all state is cleared immediately and any pending window is discarded.
- An out_ready edge with out_valid=0 is ignored.
- Simultaneous completion and drain in the same cycle: the new window replaces the drained one with no bubble.

Optional Feature:
PIX_WINDOW_ZERO_PAD_EN
- Defined, partial row: lanes cnt+1..NPIX-1 are zero-filled, and the window is emitted exactly as a completed window with out_last=1. If the output slot is stalled, the window enters FULL.
- Not defined, partial row: the partial window is discarded. asm<=0, no output, and a 1-cycle pulse on extra output port win_drop (present only when the macro is undefined, reset 0).

Decomposition:
- Shared package pix_pkg holds:
  - localparams for default PIX_W/NPIX/STRIDE;
  - the state encoding (FILL=1'b0, FULL=1'b1);
  - a lane-index width function clog2(NPIX).
- One natural sub-module: pix_window_shift. It is a combinational lane shifter (window in, STRIDE shift out, zero-fill) that the controller instantiates.

Test Plan:
- NPIX=3, STRIDE=3, out_ready=1; send 0x11,0x22,0x33 -> one cycle after the third accept, out_win=0x332211 and out_valid=1 for 1 cycle.
- NPIX=3, STRIDE=1, out_ready=1; send 1,2,3,4,5 -> windows 0x030201, 0x040302, 0x050403 on consecutive accepts.
- Stall: out_ready=0 after the first window; send 3 more pixels -> in_ready=0 after the third. Raise out_ready -> first window drained, second window appears the next cycle, in_ready=1.
- in_last on the 2nd pixel (0xAA,0xBB), macro defined -> out_win=0x00BBAA, out_last=1. Macro undefined -> no out_valid, win_drop pulse, next window starts at lane 0.
- Assert rst while in state FULL with out_valid=1 -> out_valid=0, in_ready=1, out_win=0 asynchronously. The next three pixels form a fresh window.
- Back-to-back: STRIDE=3, continuous in_valid, out_ready=1 -> in_ready never drops; a window every 3 cycles with no gaps.
